// File: rtl/c2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : c2c_pkg
// Description : Shared state encoding, default parameter values and helper
//               function for the chip-to-chip burst master.
// Revision    : 1.0 - initial release
// ============================================================================
package c2c_pkg;

    localparam int c_DEF_DATA_W         = 3;
    localparam int c_DEF_BURST_MAX      = 4;
    localparam int c_DEF_WAIT_CYCLES    = 100000000;
    localparam int c_DEF_TIMEOUT_CYCLES = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_WAIT_DLY = 3'd2,
        ST_SEND_HI  = 3'd3,
        ST_SEND_LO  = 3'd4
    } c2c_state_e;

    // Larger of two integers, used to size the shared delay/timeout counter.
    function automatic int c2c_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c2c_delay_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : c2c_delay_counter
// Description : Clearable up-counter with terminal-count compare. Counts
//               while enabled and holds once the terminal value is reached,
//               so it never wraps while a state lingers.
// Revision    : 1.0 - initial release
// ============================================================================
module c2c_delay_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_term;

    assign w_at_term = (r_count == terminal);
    assign done      = w_at_term;

    // Count up while enabled; clear has priority and saturate at terminal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !w_at_term) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/c2c_master_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : c2c_master_burst
// Description : Chip-to-chip burst master. Requests the slave, waits for ack,
//               signals a settle notice, then hands out up to BURST_MAX words
//               using a four-phase ack handshake (ack low consumes a word,
//               ack high re-arms). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module c2c_master_burst
    import c2c_pkg::*;
#(
    parameter int DATA_W         = c_DEF_DATA_W,
    parameter int BURST_MAX      = c_DEF_BURST_MAX,
    parameter int WAIT_CYCLES    = c_DEF_WAIT_CYCLES,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          request,
    input  logic                          ack,
    input  logic [$clog2(BURST_MAX+1)-1:0] burst_len,
    input  logic [DATA_W*BURST_MAX-1:0]   data_in,
    output logic                          request2s,
    output logic                          notice,
    output logic                          valid,
    output logic [DATA_W-1:0]             data,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err
);

    localparam int c_CNT_W = $clog2(c2c_max(WAIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int c_LEN_W = $clog2(BURST_MAX + 1);
    localparam int c_IDX_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    // Counter terminal values are "last count", i.e. cycles minus one.
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST  =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit                 c_TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX   = c_LEN_W'(BURST_MAX);

    c2c_state_e                  r_state;
    c2c_state_e                  w_state_nxt;
    logic                        r_request2s, w_request2s_nxt;
    logic                        r_notice, w_notice_nxt;
    logic                        r_valid, w_valid_nxt;
    logic [DATA_W-1:0]           r_data, w_data_nxt;
    logic                        r_busy, w_busy_nxt;
    logic                        r_done, w_done_nxt;
    logic                        r_timeout_err, w_timeout_err_nxt;
    logic [c_IDX_W-1:0]          r_idx, w_idx_nxt, w_idx_inc;
    logic [c_IDX_W-1:0]          r_last_idx;
    logic [DATA_W*BURST_MAX-1:0] r_payload;
    logic                        w_load;

    logic [c_LEN_W-1:0]          w_len_clamped;
    logic [c_IDX_W-1:0]          w_last_idx_in;
    logic [DATA_W-1:0]           w_words [BURST_MAX];

    logic                        w_cnt_clear;
    logic                        w_cnt_enable;
    logic [c_CNT_W-1:0]          w_cnt_terminal;
    logic                        w_cnt_done;

    // Out-of-range lengths are clamped so a transfer always moves 1..BURST_MAX words.
    assign w_len_clamped = (burst_len == '0)       ? c_LEN_W'(1) :
                           (burst_len > c_LEN_MAX) ? c_LEN_MAX   : burst_len;
    assign w_last_idx_in = c_IDX_W'(w_len_clamped - c_LEN_W'(1));
    assign w_idx_inc     = r_idx + c_IDX_W'(1);

    for (genvar gi = 0; gi < BURST_MAX; gi++) begin : g_words
        assign w_words[gi] = r_payload[gi*DATA_W +: DATA_W];
    end

    // One counter serves both the ack timeout and the settle delay; it restarts
    // from zero whenever the state changes.
    assign w_cnt_clear    = (w_state_nxt != r_state);
    assign w_cnt_enable   = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DLY);
    assign w_cnt_terminal = (r_state == ST_WAIT_DLY) ? c_WAIT_LAST : c_TMO_LAST;

    c2c_delay_counter #(
        .CNT_W    (c_CNT_W)
    ) u_delay_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_cnt_clear),
        .enable   (w_cnt_enable),
        .terminal (w_cnt_terminal),
        .done     (w_cnt_done)
    );

    // Next-state and next-output decode; registered outputs hold by default.
    always_comb begin
        w_state_nxt       = r_state;
        w_request2s_nxt   = r_request2s;
        w_notice_nxt      = r_notice;
        w_valid_nxt       = r_valid;
        w_data_nxt        = r_data;
        w_done_nxt        = 1'b0;
        w_timeout_err_nxt = 1'b0;
        w_idx_nxt         = r_idx;
        w_load            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (request) begin
                    w_state_nxt     = ST_WAIT_ACK;
                    w_request2s_nxt = 1'b1;
                    w_load          = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack) begin
                    w_state_nxt     = ST_WAIT_DLY;
                    w_request2s_nxt = 1'b0;
                    w_notice_nxt    = 1'b1;
                end else if (c_TMO_EN && w_cnt_done) begin
                    w_state_nxt       = ST_IDLE;
                    w_request2s_nxt   = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            ST_WAIT_DLY: begin
                if (w_cnt_done) begin
                    w_state_nxt  = ST_SEND_LO;
                    w_notice_nxt = 1'b0;
                    w_valid_nxt  = 1'b1;
                    w_data_nxt   = w_words[0];
                    w_idx_nxt    = '0;
                end
            end
            ST_SEND_LO: begin
                // ack low means the slave has taken the current word.
                if (!ack) begin
                    if (r_idx == r_last_idx) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_data_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_SEND_HI;
                        w_idx_nxt   = w_idx_inc;
                        w_data_nxt  = w_words[w_idx_inc];
                    end
                end
            end
            ST_SEND_HI: begin
                if (ack) begin
                    w_state_nxt = ST_SEND_LO;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_request2s_nxt = 1'b0;
                w_notice_nxt    = 1'b0;
                w_valid_nxt     = 1'b0;
                w_data_nxt      = '0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    // State, output and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_request2s   <= 1'b0;
            r_notice      <= 1'b0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_idx         <= '0;
            r_last_idx    <= '0;
            r_payload     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_request2s   <= w_request2s_nxt;
            r_notice      <= w_notice_nxt;
            r_valid       <= w_valid_nxt;
            r_data        <= w_data_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_idx         <= w_idx_nxt;
            if (w_load) begin
                r_payload  <= data_in;
                r_last_idx <= w_last_idx_in;
            end
        end
    end

    assign request2s   = r_request2s;
    assign notice      = r_notice;
    assign valid       = r_valid;
    assign data        = r_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_c2c_master_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_c2c_master_burst
// Description : Directed self-checking bench for c2c_master_burst with
//               DATA_W=3, BURST_MAX=4, WAIT_CYCLES=5, TIMEOUT_CYCLES=20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c2c_master_burst;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        request;
    logic        ack;
    logic [2:0]  burst_len;
    logic [11:0] data_in;
    logic        request2s;
    logic        notice;
    logic        valid;
    logic [2:0]  data;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [8:0]  e;
    logic [8:0]  obs;

    assign obs = {request2s, notice, valid, busy, done, timeout_err, data};

    c2c_master_burst #(
        .DATA_W         (3),
        .BURST_MAX      (4),
        .WAIT_CYCLES    (5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .ack         (ack),
        .burst_len   (burst_len),
        .data_in     (data_in),
        .request2s   (request2s),
        .notice      (notice),
        .valid       (valid),
        .data        (data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Packs expected outputs in the same order as obs.
    function automatic logic [8:0] ex(input logic r, input logic n, input logic v,
                                      input logic b, input logic d, input logic t,
                                      input logic [2:0] dat);
        return {r, n, v, b, d, t, dat};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; request = 1'b1; ack = 1'b0; burst_len = 3'd1; data_in = 12'h005;
        tick(); tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL reset_state: got %b want %b", obs, e); else n_pass++;
        request = 1'b0; rst_n = 1'b1;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL reset_idle: got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_single();
        data_in = 12'h005; burst_len = 3'd1; request = 1'b1;
        tick(); request = 1'b0;
        e = ex(1,0,0,1,0,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL single_req: got %b want %b", obs, e); else n_pass++;
        tick();
        n_total++;
        if (obs !== e) $display("FAIL single_req_hold: got %b want %b", obs, e); else n_pass++;
        ack = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            e = ex(0,1,0,1,0,0,3'd0); n_total++;
            if (obs !== e) $display("FAIL single_notice[%0d]: got %b want %b", i, obs, e); else n_pass++;
            tick();
        end
        e = ex(0,0,1,1,0,0,3'd5); n_total++;
        if (obs !== e) $display("FAIL single_data: got %b want %b", obs, e); else n_pass++;
        tick();
        n_total++;
        if (obs !== e) $display("FAIL single_data_hold: got %b want %b", obs, e); else n_pass++;
        ack = 1'b0;
        tick();
        e = ex(0,0,0,0,1,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL single_done: got %b want %b", obs, e); else n_pass++;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL single_idle: got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_burst3();
        logic [2:0] w [3];
        w = '{3'd1, 3'd2, 3'd7};
        data_in = 12'h1D1; burst_len = 3'd3; request = 1'b1;
        tick(); request = 1'b0; ack = 1'b1;
        tick();
        repeat (5) tick();
        e = ex(0,0,1,1,0,0,w[0]); n_total++;
        if (obs !== e) $display("FAIL burst_w0: got %b want %b", obs, e); else n_pass++;
        for (int k = 1; k < 3; k++) begin
            ack = 1'b0; tick();
            e = ex(0,0,1,1,0,0,w[k]); n_total++;
            if (obs !== e) $display("FAIL burst_hi[%0d]: got %b want %b", k, obs, e); else n_pass++;
            ack = 1'b1; tick();
            n_total++;
            if (obs !== e) $display("FAIL burst_lo[%0d]: got %b want %b", k, obs, e); else n_pass++;
        end
        ack = 1'b0; tick();
        e = ex(0,0,0,0,1,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL burst_done: got %b want %b", obs, e); else n_pass++;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL burst_idle: got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_timeout();
        ack = 1'b0; burst_len = 3'd2; data_in = 12'h0AB; request = 1'b1;
        tick(); request = 1'b0;
        for (int i = 0; i < 20; i++) begin
            e = ex(1,0,0,1,0,0,3'd0); n_total++;
            if (obs !== e) $display("FAIL tmo_wait[%0d]: got %b want %b", i, obs, e); else n_pass++;
            tick();
        end
        e = ex(0,0,0,0,0,1,3'd0); n_total++;
        if (obs !== e) $display("FAIL tmo_pulse: got %b want %b", obs, e); else n_pass++;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL tmo_idle: got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_ignore_request();
        ack = 1'b0; data_in = 12'h033; burst_len = 3'd2; request = 1'b1;
        tick(); request = 1'b0; ack = 1'b1;
        tick();
        data_in = 12'hFFF; burst_len = 3'd1; request = 1'b1;
        tick(); request = 1'b0;
        e = ex(0,1,0,1,0,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL ign_dly: got %b want %b", obs, e); else n_pass++;
        repeat (4) tick();
        e = ex(0,0,1,1,0,0,3'd3); n_total++;
        if (obs !== e) $display("FAIL ign_w0: got %b want %b", obs, e); else n_pass++;
        request = 1'b1;
        tick(); request = 1'b0;
        n_total++;
        if (obs !== e) $display("FAIL ign_send_lo: got %b want %b", obs, e); else n_pass++;
        ack = 1'b0; tick();
        e = ex(0,0,1,1,0,0,3'd6); n_total++;
        if (obs !== e) $display("FAIL ign_w1: got %b want %b", obs, e); else n_pass++;
        ack = 1'b1; tick();
        ack = 1'b0; tick();
        e = ex(0,0,0,0,1,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL ign_done: got %b want %b", obs, e); else n_pass++;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL ign_idle: got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_reset_midburst();
        ack = 1'b0; data_in = 12'h1D1; burst_len = 3'd3; request = 1'b1;
        tick(); request = 1'b0; ack = 1'b1;
        tick();
        repeat (5) tick();
        ack = 1'b0; tick();
        e = ex(0,0,1,1,0,0,3'd2); n_total++;
        if (obs !== e) $display("FAIL rst_pre: got %b want %b", obs, e); else n_pass++;
        rst_n = 1'b0;
        tick();
        e = '0; n_total++;
        if (obs !== e) $display("FAIL rst_mid: got %b want %b", obs, e); else n_pass++;
        rst_n = 1'b1; ack = 1'b0;
        tick();
        n_total++;
        if (obs !== e) $display("FAIL rst_idle: got %b want %b", obs, e); else n_pass++;
        data_in = 12'h004; burst_len = 3'd1; request = 1'b1;
        tick(); request = 1'b0;
        e = ex(1,0,0,1,0,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL rst_new_req: got %b want %b", obs, e); else n_pass++;
        ack = 1'b1; tick();
        repeat (5) tick();
        e = ex(0,0,1,1,0,0,3'd4); n_total++;
        if (obs !== e) $display("FAIL rst_new_data: got %b want %b", obs, e); else n_pass++;
        ack = 1'b0; tick();
        e = ex(0,0,0,0,1,0,3'd0); n_total++;
        if (obs !== e) $display("FAIL rst_new_done: got %b want %b", obs, e); else n_pass++;
        tick();
    endtask

    task automatic test_clamp();
        logic [2:0] w [4];
        logic [2:0] lens [2];
        int         nwords [2];
        w      = '{3'd5, 3'd6, 3'd7, 3'd1};
        lens   = '{3'd0, 3'd6};
        nwords = '{1, 4};
        for (int c = 0; c < 2; c++) begin
            ack = 1'b0; data_in = 12'h3F5; burst_len = lens[c]; request = 1'b1;
            tick(); request = 1'b0; ack = 1'b1;
            tick();
            repeat (5) tick();
            e = ex(0,0,1,1,0,0,w[0]); n_total++;
            if (obs !== e) $display("FAIL clamp%0d_w0: got %b want %b", c, obs, e); else n_pass++;
            for (int k = 0; k < nwords[c]; k++) begin
                ack = 1'b0; tick();
                if (k == nwords[c] - 1) begin
                    e = ex(0,0,0,0,1,0,3'd0); n_total++;
                    if (obs !== e) $display("FAIL clamp%0d_done: got %b want %b", c, obs, e); else n_pass++;
                end else begin
                    e = ex(0,0,1,1,0,0,w[k+1]); n_total++;
                    if (obs !== e) $display("FAIL clamp%0d_hi[%0d]: got %b want %b", c, k, obs, e); else n_pass++;
                    ack = 1'b1; tick();
                    n_total++;
                    if (obs !== e) $display("FAIL clamp%0d_lo[%0d]: got %b want %b", c, k, obs, e); else n_pass++;
                end
            end
            tick();
            e = '0; n_total++;
            if (obs !== e) $display("FAIL clamp%0d_idle: got %b want %b", c, obs, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst3();
        test_timeout();
        test_ignore_request();
        test_reset_midburst();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d passed want %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
